// File: rtl/accel_avg_filter.sv
// accel_avg_filter: moving average of signed SPI accelerometer samples, held stable for the display
//   Parameters: LOG2_DEPTH (window = 2^LOG2_DEPTH samples, 1..5), DEADBAND (LSBs, deadband build only)
//   Optional:   define ACCEL_AVG_DEADBAND_EN to suppress output updates within +/-DEADBAND of the held value
//   Ports:      clk        system clock
//               reset      asynchronous active-low reset
//               data_in    two's-complement sample
//               data_valid one-cycle strobe qualifying data_in
//               clear      synchronous flush of the window (active high, wins over data_valid)
//               data_out   averaged sample, held between updates
//               out_valid  one-cycle pulse when data_out is loaded
//               filled     high once the window holds 2^LOG2_DEPTH samples
module accel_avg_filter #(
   parameter int LOG2_DEPTH = 3,
   parameter int DEADBAND = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       clear,
   output logic [7:0] data_out,
   output logic       out_valid,
   output logic       filled
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW = 8 + LOG2_DEPTH;
`ifdef ACCEL_AVG_DEADBAND_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif
   typedef enum logic {FILL, RUN} state_t;
   state_t state, state_d;
   logic signed [7:0] win [DEPTH];
   logic [LOG2_DEPTH-1:0] wptr;
   logic signed [SW-1:0] sum;
   logic upd, upd_first, accept, last_fill, hold;
   logic [7:0] avg;
   logic signed [8:0] diff, mag;
   assign accept = data_valid && !clear;
   // During FILL the write pointer doubles as the fill count
   assign last_fill = state == FILL && wptr == LOG2_DEPTH'(DEPTH - 1);
   assign avg = 8'(sum >>> LOG2_DEPTH);
   assign filled = state == RUN;
   assign diff = $signed({avg[7], avg}) - $signed({data_out[7], data_out});
   assign mag = diff < 0 ? -diff : diff;
   // The first output after a fill always loads, whatever the held value
   assign hold = DB_EN && !upd_first && mag <= $signed(9'(DEADBAND));
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= FILL;
      else state <= state_d;
   always_comb begin
      state_d = state;
      if (clear) state_d = FILL;
      else if (accept && last_fill) state_d = RUN;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) win[i] <= '0;
         wptr <= '0;
         sum <= '0;
         upd <= 1'b0;
         upd_first <= 1'b0;
         data_out <= '0;
         out_valid <= 1'b0;
      end else begin
         upd <= accept && (state == RUN || last_fill);
         upd_first <= accept && last_fill;
         out_valid <= 1'b0;
         if (clear) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wptr <= '0;
            sum <= '0;
         end else if (accept) begin
            sum <= sum + SW'($signed(data_in)) - SW'(win[wptr]);
            win[wptr] <= $signed(data_in);
            wptr <= wptr + 1'b1;
         end
         // A clear arriving while an update is pending cancels it
         if (!clear && upd && !hold) begin
            data_out <= avg;
            out_valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_accel_avg_filter.sv
// tb_accel_avg_filter: scoreboard bench for accel_avg_filter with directed vectors
module tb_accel_avg_filter;
   logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0, clear = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic out_valid, filled;
   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];

   always #4 clk = ~clk;

   accel_avg_filter #(.LOG2_DEPTH(3), .DEADBAND(2)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .clear(clear), .data_out(data_out), .out_valid(out_valid), .filled(filled)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (reset && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=%h required=none", data_out);
         end else check("scoreboard_data_out", data_out, exp_q.pop_front());
      end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d);
      data_in = d;
      data_valid = 1'b1;
      tick(1);
      data_valid = 1'b0;
   endtask

   task automatic fill(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) send(d);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      tick(2);
      check("reset_data_out", data_out, 8'h00);
      check("reset_out_valid", {7'b0, out_valid}, 8'h00);
      check("reset_filled", {7'b0, filled}, 8'h00);
      reset = 1'b1;
      tick(1);
      // fill with 0x10, filled on the 8th, output two edges after the strobe
      for (int i = 0; i < 8; i++) begin
         if (i == 7) exp_q.push_back(8'h10);
         send(8'h10);
         check("t1_filled", {7'b0, filled}, {7'b0, i == 7});
      end
      check("t1_latency_n1", {7'b0, out_valid}, 8'h00);
      tick(1);
      check("t1_latency_n2", {7'b0, out_valid}, 8'h01);
      check("t1_data_out", data_out, 8'h10);
      tick(1);
      check("t1_pulse_width", {7'b0, out_valid}, 8'h00);
      // negative samples and floor rounding
      do_clear();
      check("t2_clear_filled", {7'b0, filled}, 8'h00);
      check("t2_clear_hold", data_out, 8'h10);
      exp_q.push_back(8'hFD);
      fill(8'hFD, 8);
      tick(3);
      check("t2_neg_avg", data_out, 8'hFD);
      do_clear();
      fill(8'h00, 7);
      exp_q.push_back(8'hFF);
      send(8'hFF);
      tick(3);
      check("t2_floor", data_out, 8'hFF);
      // eviction of the oldest sample and pointer wrap
      do_clear();
      exp_q.push_back(8'h10);
      fill(8'h10, 8);
      tick(3);
      exp_q.push_back(8'h18);
      send(8'h50);
      tick(3);
      check("t3_evict1", data_out, 8'h18);
      exp_q.push_back(8'h20);
      send(8'h50);
      tick(3);
      check("t3_evict2", data_out, 8'h20);
      // reset mid-fill discards the partial window
      do_clear();
      fill(8'h20, 4);
      reset = 1'b0;
      tick(1);
      check("t4_reset_data_out", data_out, 8'h00);
      check("t4_reset_filled", {7'b0, filled}, 8'h00);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) exp_q.push_back(8'h08);
         send(8'h08);
         check("t4_filled", {7'b0, filled}, {7'b0, i == 7});
      end
      tick(3);
      check("t4_data_out", data_out, 8'h08);
      // clear right after a RUN sample cancels its pending update
      send(8'h48);
      do_clear();
      tick(3);
      check("cancel_hold", data_out, 8'h08);
      check("cancel_filled", {7'b0, filled}, 8'h00);
      // clear together with a sample drops the sample
      exp_q.push_back(8'h08);
      fill(8'h08, 8);
      tick(3);
      data_in = 8'h7F;
      data_valid = 1'b1;
      clear = 1'b1;
      tick(1);
      data_valid = 1'b0;
      clear = 1'b0;
      check("t5_filled", {7'b0, filled}, 8'h00);
      tick(3);
      check("t5_hold", data_out, 8'h08);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) exp_q.push_back(8'h7F);
         send(8'h7F);
         check("t5_refill", {7'b0, filled}, {7'b0, i == 7});
      end
      tick(3);
      check("t5_data_out", data_out, 8'h7F);
      // small change then large change against the held output
      do_clear();
      exp_q.push_back(8'h18);
      fill(8'h18, 8);
      tick(3);
`ifndef ACCEL_AVG_DEADBAND_EN
      exp_q.push_back(8'h19);
`endif
      send(8'h20);
      tick(3);
`ifdef ACCEL_AVG_DEADBAND_EN
      check("t6_small_step", data_out, 8'h18);
`else
      check("t6_small_step", data_out, 8'h19);
`endif
      exp_q.push_back(8'h1C);
      send(8'h30);
      tick(3);
      check("t6_large_step", data_out, 8'h1C);
      tick(5);
      check("queue_drain", 8'(exp_q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
